// File: rtl/cpu_pkg.sv
// Shared core types: datapath widths, PC increment and the fetch queue entry.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries; wrap-bit pointers give full/empty/count directly.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         empty,
  output logic         full,
  output logic [AW:0]  count
);
  fetch_entry_t mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty && !flush;
  // a pop frees the slot the push lands in, so a full queue still accepts push+pop
  assign do_push = push && (!full || do_pop) && !flush;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/fetch_unit_pf.sv
// Instruction-fetch front end: credit-limited imem requests, prefetch queue, redirect flush.
module fetch_unit_pf #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            if_id_valid,
  input  logic            if_id_ready,
  output logic [XLEN-1:0] if_id_pc,
  output logic [ILEN-1:0] if_id_inst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i
);
  import cpu_pkg::*;

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] fetch_pc, rsp_pc;
  logic [OW-1:0]   outstanding, discard;
  logic [AW:0]     count;
  logic            q_empty, q_full, q_push, q_pop;
  logic            req_fire, rsp_fire;
  fetch_entry_t    head, push_data;

  assign rsp_fire = imem_rsp_valid;

  // every request in flight already owns a queue slot, so responses never need back-pressure
  assign imem_req_valid = !rst && !redirect_i && (int'(outstanding) < MAX_OUT)
                          && ((int'(count) + int'(outstanding)) < DEPTH);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign q_push    = rsp_fire && (discard == '0) && !redirect_i;
  assign q_pop     = if_id_valid && if_id_ready && !redirect_i;
  assign push_data = '{pc: rsp_pc, inst: imem_rsp_data};

  assign if_id_valid = !q_empty;
  assign if_id_pc    = if_id_valid ? head.pc   : '0;
  assign if_id_inst  = if_id_valid ? head.inst : '0;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_i),
    .push     (q_push),
    .push_data(push_data),
    .pop      (q_pop),
    .head     (head),
    .empty    (q_empty),
    .full     (q_full),
    .count    (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_i) begin
      fetch_pc    <= {redirect_pc_i[XLEN-1:2], 2'b00};
      rsp_pc      <= {redirect_pc_i[XLEN-1:2], 2'b00};
      outstanding <= outstanding - OW'(rsp_fire);
      discard     <= outstanding - OW'(rsp_fire);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
      if (q_push)   rsp_pc   <= rsp_pc + PC_STEP;
      outstanding <= outstanding + OW'(req_fire) - OW'(rsp_fire);
      if (rsp_fire && (discard != '0)) discard <= discard - OW'(1);
    end
  end

`ifndef SYNTHESIS
  a_counters: assert property (@(posedge clk) disable iff (rst)
    (discard <= outstanding) && (int'(outstanding) <= MAX_OUT));
  a_credit: assert property (@(posedge clk) disable iff (rst)
    (int'(count) + int'(outstanding)) <= DEPTH);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(q_push && q_full && !q_pop));
`endif
endmodule

// File: tb/tb_fetch_unit_pf.sv
// Directed bench for fetch_unit_pf: in-order imem model plus a scoreboard checked at each decode handshake.
module tb_fetch_unit_pf;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_id_valid;
  logic        if_id_ready = 1'b0;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int first_pop_cyc = -1;
  logic mem_hold = 1'b0;

  logic [31:0]  mem_q[$];
  logic [31:0]  req_log[$];
  int           req_cyc[$];
  fetch_entry_t sb_q[$];
  fetch_entry_t mon_e;

  fetch_unit_pf #(.XLEN(32), .ILEN(32), .DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .if_id_valid   (if_id_valid),
    .if_id_ready   (if_id_ready),
    .if_id_pc      (if_id_pc),
    .if_id_inst    (if_id_inst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    return (req_log.size() > i) ? req_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int cyc_at(input int i);
    return (req_cyc.size() > i) ? req_cyc[i] : -1000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // imem: one-cycle latency, in order, optionally held off
  always begin
    @(negedge clk);
    if (!mem_hold && mem_q.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  // monitor: records request fires, checks every decode handshake against the scoreboard
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (imem_req_valid && imem_req_ready) begin
        mem_q.push_back(imem_req_addr);
        req_log.push_back(imem_req_addr);
        req_cyc.push_back(cyc);
      end
      if (if_id_valid && if_id_ready && !redirect_i) begin
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pop: got pc %h, nothing expected", if_id_pc);
        end else begin
          mon_e = sb_q.pop_front();
          if (if_id_pc !== mon_e.pc || if_id_inst !== mon_e.inst) begin
            bad++;
            $display("FAIL decode_entry: got pc %h inst %h expected pc %h inst %h",
                     if_id_pc, if_id_inst, mon_e.pc, mon_e.inst);
          end
        end
      end
    end
  end

  task automatic expect_seq(input logic [31:0] base, input int n);
    logic [31:0] pc;
    pc = base;
    for (int i = 0; i < n; i++) begin
      sb_q.push_back('{pc: pc, inst: inst_of(pc)});
      pc = pc + 32'd4;
    end
  endtask

  task automatic consume(input string name, input int budget);
    int w;
    w = 0;
    @(negedge clk);
    if_id_ready = 1'b1;
    while (sb_q.size() > 0 && w < budget) begin
      @(negedge clk);
      w++;
    end
    if_id_ready = 1'b0;
    chk(name, sb_q.size(), 0);
  endtask

  task automatic do_reset(input logic hold);
    @(negedge clk);
    rst = 1'b1;
    redirect_i = 1'b0;
    if_id_ready = 1'b0;
    repeat (3) @(posedge clk);
    mem_hold = hold;
    mem_q.delete();
    sb_q.delete();
    req_log.delete();
    req_cyc.delete();
    first_pop_cyc = -1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic redirect(input string name, input logic [31:0] pc);
    @(negedge clk);
    redirect_i = 1'b1;
    redirect_pc_i = pc;
    sb_q.delete();
    #1;
    chk({name, "_req_blocked"}, imem_req_valid, 1'b0);
    @(negedge clk);
    redirect_i = 1'b0;
    req_log.delete();
    req_cyc.delete();
    #1;
    chk({name, "_flushed"}, if_id_valid, 1'b0);
  endtask

  initial begin
    #2;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_if_id_valid", if_id_valid, 1'b0);
    chk("rst_if_id_pc", if_id_pc, 32'h0);
    chk("rst_if_id_inst", if_id_inst, 32'h0);

    // streaming fetch
    do_reset(1'b0);
    expect_seq(32'h0, 6);
    consume("stream_drain", 40);
    chk("stream_addr0", log_at(0), 32'h0);
    chk("stream_addr1", log_at(1), 32'h4);
    chk("stream_addr2", log_at(2), 32'h8);
    chk("stream_b2b_01", cyc_at(1) - cyc_at(0), 1);
    chk("stream_b2b_12", cyc_at(2) - cyc_at(1), 1);
    chk("stream_latency", first_pop_cyc - cyc_at(0), 2);

    // decode stall fills the queue
    do_reset(1'b0);
    repeat (12) @(negedge clk);
    #2;
    chk("stall_req_count", req_log.size(), 4);
    chk("stall_req_valid", imem_req_valid, 1'b0);
    chk("stall_head_valid", if_id_valid, 1'b1);
    chk("stall_head_pc", if_id_pc, 32'h0);
    chk("stall_head_inst", if_id_inst, inst_of(32'h0));
    repeat (3) @(negedge clk);
    #2;
    chk("stall_head_pc_hold", if_id_pc, 32'h0);
    expect_seq(32'h0, 8);
    consume("stall_resume_drain", 60);

    // redirect with two stale requests in flight
    do_reset(1'b1);
    repeat (4) @(negedge clk);
    #2;
    chk("maxout_req_valid", imem_req_valid, 1'b0);
    chk("maxout_req_count", req_log.size(), 2);
    redirect("redir103", 32'h0000_0103);
    @(posedge clk);
    mem_hold = 1'b0;
    expect_seq(32'h100, 3);
    consume("redir103_drain", 40);
    chk("redir103_first_addr", log_at(0), 32'h100);

    // redirect coinciding with a response and a pop
    do_reset(1'b0);
    repeat (10) @(negedge clk);
    @(posedge clk);
    mem_hold = 1'b1;
    expect_seq(32'h0, 2);
    consume("coinc_pre_drain", 20);
    repeat (4) @(negedge clk);
    #2;
    chk("coinc_held_req_valid", imem_req_valid, 1'b0);
    chk("coinc_req_count", req_log.size(), 6);
    @(posedge clk);
    mem_hold = 1'b0;
    @(negedge clk);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h300;
    if_id_ready = 1'b1;
    sb_q.delete();
    #1;
    chk("coinc_head_valid", if_id_valid, 1'b1);
    chk("coinc_req_blocked", imem_req_valid, 1'b0);
    @(negedge clk);
    redirect_i = 1'b0;
    if_id_ready = 1'b0;
    req_log.delete();
    req_cyc.delete();
    #1;
    chk("coinc_flushed", if_id_valid, 1'b0);
    expect_seq(32'h300, 2);
    consume("coinc_drain", 40);
    chk("coinc_first_addr", log_at(0), 32'h300);

    // PC wrap at the top of the address space
    redirect("wrap", 32'hFFFF_FFFC);
    expect_seq(32'hFFFF_FFFC, 3);
    consume("wrap_drain", 40);
    chk("wrap_addr0", log_at(0), 32'hFFFF_FFFC);
    chk("wrap_addr1", log_at(1), 32'h0);

    // async reset with requests in flight
    redirect("pre_rst", 32'h500);
    repeat (8) @(negedge clk);
    @(posedge clk);
    mem_hold = 1'b1;
    expect_seq(32'h500, 2);
    consume("pre_rst_drain", 20);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_req_valid", imem_req_valid, 1'b0);
    chk("arst_if_id_valid", if_id_valid, 1'b0);
    chk("arst_if_id_pc", if_id_pc, 32'h0);
    chk("arst_if_id_inst", if_id_inst, 32'h0);
    @(posedge clk);
    mem_hold = 1'b0;
    repeat (4) @(posedge clk);
    mem_q.delete();
    sb_q.delete();
    req_log.delete();
    req_cyc.delete();
    @(negedge clk);
    rst = 1'b0;
    expect_seq(32'h0, 2);
    consume("post_rst_drain", 40);
    chk("post_rst_first_addr", log_at(0), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
